// File: rtl/tlul_cmd_host_pkg.sv
`default_nettype none
// ============================================================================
// Module      : tlul_cmd_host_pkg
// Description : State encoding and captured-command record for tlul_cmd_host.
// Revision    : 1.0 - initial release
// ============================================================================
package tlul_cmd_host_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    A_REQ  = 2'd1,
    D_WAIT = 2'd2,
    RSP    = 2'd3
  } state_e;

  typedef struct packed {
    logic        write;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  mask;
  } cmd_t;

endpackage
`default_nettype wire

// File: rtl/tlul_pkg.sv
`default_nettype none
// ============================================================================
// Module      : tlul_pkg
// Description : TL-UL types and opcodes shared by hosts and devices
//               (32-bit data, 8-bit source, single-beat transfers).
// Revision    : 1.0 - initial release
// ============================================================================
package tlul_pkg;

  typedef enum logic [2:0] {
    PutFullData    = 3'h0,
    PutPartialData = 3'h1,
    Get            = 3'h4
  } tl_a_op_e;

  typedef enum logic [2:0] {
    AccessAck     = 3'h0,
    AccessAckData = 3'h1
  } tl_d_op_e;

  typedef struct packed {
    logic [4:0] rsvd;
    logic [3:0] instr_type;
    logic [6:0] cmd_intg;
    logic [6:0] data_intg;
  } tl_a_user_t;

  localparam tl_a_user_t TL_A_USER_DEFAULT = '{
    rsvd:       5'h00,
    instr_type: 4'h9,
    cmd_intg:   7'h00,
    data_intg:  7'h00
  };

  typedef struct packed {
    logic        a_valid;
    tl_a_op_e    a_opcode;
    logic [2:0]  a_param;
    logic [1:0]  a_size;
    logic [7:0]  a_source;
    logic [31:0] a_address;
    logic [3:0]  a_mask;
    logic [31:0] a_data;
    tl_a_user_t  a_user;
    logic        d_ready;
  } tl_h2d_t;

  typedef struct packed {
    logic        d_valid;
    tl_d_op_e    d_opcode;
    logic [2:0]  d_param;
    logic [1:0]  d_size;
    logic [7:0]  d_source;
    logic        d_sink;
    logic [31:0] d_data;
    logic [13:0] d_user;
    logic        d_error;
    logic        a_ready;
  } tl_d2h_t;

endpackage
`default_nettype wire

// File: rtl/tlul_cmd_host_tmr.sv
`default_nettype none
// ============================================================================
// Module      : tlul_cmd_host_tmr
// Description : D-channel wait counter. Counts enabled cycles from a clear
//               and flags expiry on the cycle the count reaches
//               TIMEOUT_CYCLES-1.
// Ports       : clk_i, rst_i (async, active high), clear_i, enable_i,
//               expired_o
// Revision    : 1.0 - initial release
// ============================================================================
module tlul_cmd_host_tmr #(
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clear_i,
  input  logic enable_i,
  output logic expired_o
);

  localparam int unsigned CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // Saturate at LAST so a held enable cannot wrap back to zero.
  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (enable_i && (cnt_q != LAST)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = enable_i && (cnt_q == LAST);

endmodule
`default_nettype wire

// File: rtl/tlul_cmd_host.sv
`default_nettype none
// ============================================================================
// Module      : tlul_cmd_host
// Description : Single-outstanding TL-UL host. Converts a valid/ready command
//               stream into A-channel requests and returns D-channel results
//               on a valid/ready response port.
// Ports       : clk_i, rst_i (async assert, active high)
//               cmd_*  : command stream in (valid/ready)
//               rsp_*  : response stream out (valid/ready)
//               busy_o : transaction in flight
//               tl_o / tl_i : TL-UL host-to-device / device-to-host
// Options     : TLUL_CMD_HOST_TIMEOUT_EN enables the D-channel timeout.
// Revision    : 1.0 - initial release
// ============================================================================
module tlul_cmd_host
  import tlul_pkg::*;
  import tlul_cmd_host_pkg::*;
#(
  parameter int unsigned TimeoutCycles = 1024,
  parameter logic [7:0]  SourceId      = 8'h00
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        cmd_valid_i,
  output logic        cmd_ready_o,
  input  logic        cmd_write_i,
  input  logic [31:0] cmd_addr_i,
  input  logic [31:0] cmd_wdata_i,
  input  logic [3:0]  cmd_mask_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [31:0] rsp_rdata_o,
  output logic        rsp_error_o,
  output logic        rsp_timeout_o,
  output logic        busy_o,
  output tl_h2d_t     tl_o,
  input  tl_d2h_t     tl_i
);

  // Reset asserts asynchronously and releases two clocks after rst_i falls.
  logic [1:0] rst_sync_q;
  logic       rst_int;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rst_sync_q <= 2'b11;
    end else begin
      rst_sync_q <= {rst_sync_q[0], 1'b0};
    end
  end

  assign rst_int = rst_sync_q[1];

  state_e      state_q, state_d;
  cmd_t        cmd_q;
  logic [31:0] rsp_rdata_q;
  logic        rsp_error_q;
  logic        cmd_hs;
  logic        d_capture;
  logic        to_capture;
  logic        a_valid;
  logic        d_ready;
  logic        tmr_expired;

`ifdef TLUL_CMD_HOST_TIMEOUT_EN
  logic tmr_clear;
  logic tmr_enable;
  logic rsp_timeout_q;
`endif

  always_comb begin
    state_d     = state_q;
    cmd_ready_o = 1'b0;
    a_valid     = 1'b0;
    d_ready     = 1'b0;
    rsp_valid_o = 1'b0;
    cmd_hs      = 1'b0;
    d_capture   = 1'b0;
    to_capture  = 1'b0;
`ifdef TLUL_CMD_HOST_TIMEOUT_EN
    tmr_clear   = 1'b0;
    tmr_enable  = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        // d_ready stays high so stray or late responses are drained.
        cmd_ready_o = 1'b1;
        d_ready     = 1'b1;
        if (cmd_valid_i) begin
          cmd_hs  = 1'b1;
          state_d = A_REQ;
        end
      end
      A_REQ: begin
        a_valid = 1'b1;
        if (tl_i.a_ready) begin
          state_d = D_WAIT;
`ifdef TLUL_CMD_HOST_TIMEOUT_EN
          tmr_clear = 1'b1;
`endif
        end
      end
      D_WAIT: begin
        d_ready = 1'b1;
`ifdef TLUL_CMD_HOST_TIMEOUT_EN
        tmr_enable = 1'b1;
`endif
        // A real response beats expiry in the same cycle.
        if (tl_i.d_valid) begin
          d_capture = 1'b1;
          state_d   = RSP;
        end else if (tmr_expired) begin
          to_capture = 1'b1;
          state_d    = RSP;
        end
      end
      RSP: begin
        rsp_valid_o = 1'b1;
        if (rsp_ready_i) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef TLUL_CMD_HOST_TIMEOUT_EN
  tlul_cmd_host_tmr #(
    .TIMEOUT_CYCLES (TimeoutCycles)
  ) u_tmr (
    .clk_i     (clk_i),
    .rst_i     (rst_int),
    .clear_i   (tmr_clear),
    .enable_i  (tmr_enable),
    .expired_o (tmr_expired)
  );
`else
  assign tmr_expired = 1'b0;
`endif

  always_ff @(posedge clk_i or posedge rst_int) begin
    if (rst_int) begin
      state_q <= IDLE;
      cmd_q   <= '0;
    end else begin
      state_q <= state_d;
      if (cmd_hs) begin
        cmd_q.write <= cmd_write_i;
        cmd_q.addr  <= {cmd_addr_i[31:2], 2'b00};
        cmd_q.wdata <= cmd_wdata_i;
        cmd_q.mask  <= cmd_mask_i;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_int) begin
    if (rst_int) begin
      rsp_rdata_q <= '0;
      rsp_error_q <= 1'b0;
    end else if (d_capture) begin
      // Only a clean read data-ack carries data out.
      rsp_rdata_q <= (!cmd_q.write && (tl_i.d_opcode == AccessAckData) && !tl_i.d_error)
                     ? tl_i.d_data : 32'h0;
      rsp_error_q <= tl_i.d_error;
    end else if (to_capture) begin
      rsp_rdata_q <= 32'h0;
      rsp_error_q <= 1'b1;
    end
  end

`ifdef TLUL_CMD_HOST_TIMEOUT_EN
  always_ff @(posedge clk_i or posedge rst_int) begin
    if (rst_int) begin
      rsp_timeout_q <= 1'b0;
    end else if (d_capture) begin
      rsp_timeout_q <= 1'b0;
    end else if (to_capture) begin
      rsp_timeout_q <= 1'b1;
    end
  end
  assign rsp_timeout_o = rsp_timeout_q;
`else
  assign rsp_timeout_o = 1'b0;
`endif

  assign rsp_rdata_o = rsp_rdata_q;
  assign rsp_error_o = rsp_error_q;
  assign busy_o      = (state_q != IDLE);

  always_comb begin
    tl_o           = '0;
    tl_o.a_valid   = a_valid;
    tl_o.a_param   = 3'h0;
    tl_o.a_size    = 2'd2;
    tl_o.a_source  = SourceId;
    tl_o.a_address = cmd_q.addr;
    tl_o.a_data    = cmd_q.wdata;
    tl_o.a_user    = TL_A_USER_DEFAULT;
    tl_o.d_ready   = d_ready;
    if (!cmd_q.write) begin
      tl_o.a_opcode = Get;
      tl_o.a_mask   = 4'hF;
    end else if (cmd_q.mask == 4'hF) begin
      tl_o.a_opcode = PutFullData;
      tl_o.a_mask   = 4'hF;
    end else begin
      tl_o.a_opcode = PutPartialData;
      tl_o.a_mask   = cmd_q.mask;
    end
  end

  // Response metadata and the sub-word address bits carry no meaning here.
  logic w_unused_tl;
  assign w_unused_tl = ^{tl_i.d_param, tl_i.d_size, tl_i.d_source, tl_i.d_sink,
                         tl_i.d_user, cmd_addr_i[1:0]};

endmodule
`default_nettype wire

// File: tb/tb_tlul_cmd_host.sv
`default_nettype none
// ============================================================================
// Module      : tb_tlul_cmd_host
// Description : Directed self-checking bench for tlul_cmd_host with a small
//               register-file device behind the TL-UL port.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tlul_cmd_host;
  import tlul_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_write = 1'b0;
  logic [31:0] cmd_addr  = '0;
  logic [31:0] cmd_wdata = '0;
  logic [3:0]  cmd_mask  = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_rdata;
  logic        rsp_error;
  logic        rsp_timeout;
  logic        busy;
  tl_h2d_t     tl_h;
  tl_d2h_t     tl_d;

  int n_vec = 0;
  int n_err = 0;
  int a_hs  = 0;

  // Device register contents
  logic [31:0] m_ctrl = 32'h0;
  logic [31:0] m_tv   = 32'h0000_1234;
  logic [31:0] m_cmp  = 32'h0;

  always #5 clk = ~clk;

  tlul_cmd_host #(
    .TimeoutCycles (16),
    .SourceId      (8'h00)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .cmd_valid_i   (cmd_valid),
    .cmd_ready_o   (cmd_ready),
    .cmd_write_i   (cmd_write),
    .cmd_addr_i    (cmd_addr),
    .cmd_wdata_i   (cmd_wdata),
    .cmd_mask_i    (cmd_mask),
    .rsp_valid_o   (rsp_valid),
    .rsp_ready_i   (rsp_ready),
    .rsp_rdata_o   (rsp_rdata),
    .rsp_error_o   (rsp_error),
    .rsp_timeout_o (rsp_timeout),
    .busy_o        (busy),
    .tl_o          (tl_h),
    .tl_i          (tl_d)
  );

  always @(posedge clk) begin
    if (tl_h.a_valid && tl_d.a_ready) a_hs = a_hs + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                        input logic [3:0] m);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (m[b]) r[b*8 +: 8] = nw[b*8 +: 8];
    return r;
  endfunction

  // Presents the command, checks the A channel for every a_valid cycle and
  // completes the A handshake after a_stall back-pressure cycles.
  task automatic issue(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [3:0] mask, input int a_stall,
                       input logic [2:0] exp_op, input logic [3:0] exp_mask);
    int hs0;
    logic [31:0] exp_addr;
    exp_addr  = {addr[31:2], 2'b00};
    cmd_valid = 1'b1;
    cmd_write = wr;
    cmd_addr  = addr;
    cmd_wdata = wdata;
    cmd_mask  = mask;
    chk("cmd_ready_idle", {31'b0, cmd_ready}, 32'h1);
    cyc();
    cmd_valid = 1'b0;
    cmd_addr  = 32'hFFFF_FFFF;
    cmd_wdata = 32'h0;
    cmd_mask  = 4'h0;
    hs0 = a_hs;
    for (int i = 0; i <= a_stall; i++) begin
      chk("a_valid", {31'b0, tl_h.a_valid}, 32'h1);
      chk("a_opcode", {29'b0, tl_h.a_opcode}, {29'b0, exp_op});
      chk("a_address", tl_h.a_address, exp_addr);
      chk("a_mask", {28'b0, tl_h.a_mask}, {28'b0, exp_mask});
      chk("a_size", {30'b0, tl_h.a_size}, 32'd2);
      chk("d_ready_areq", {31'b0, tl_h.d_ready}, 32'h0);
      chk("cmd_ready_areq", {31'b0, cmd_ready}, 32'h0);
      if (wr) chk("a_data", tl_h.a_data, wdata);
      tl_d.a_ready = (i == a_stall);
      cyc();
    end
    tl_d.a_ready = 1'b0;
    chk("a_hs_count", a_hs - hs0, 32'd1);
    chk("a_valid_dwait", {31'b0, tl_h.a_valid}, 32'h0);
    chk("d_ready_dwait", {31'b0, tl_h.d_ready}, 32'h1);
  endtask

  // Device answers in D_WAIT using its register contents.
  task automatic respond(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] mask);
    logic [31:0] a;
    logic        hit;
    logic [31:0] rd;
    a   = {addr[31:2], 2'b00};
    hit = (a == 32'h000) || (a == 32'h104) || (a == 32'h10C);
    rd  = 32'hDEAD_BEEF;
    if (hit && !wr) begin
      rd = (a == 32'h000) ? m_ctrl : (a == 32'h104) ? m_tv : m_cmp;
    end
    if (hit && wr) begin
      if (a == 32'h000) m_ctrl = merge(m_ctrl, wdata, mask);
      if (a == 32'h104) m_tv   = merge(m_tv, wdata, mask);
      if (a == 32'h10C) m_cmp  = merge(m_cmp, wdata, mask);
      rd = 32'hA5A5_A5A5;
    end
    tl_d.d_valid  = 1'b1;
    tl_d.d_opcode = wr ? AccessAck : AccessAckData;
    tl_d.d_data   = rd;
    tl_d.d_error  = !hit;
    cyc();
    tl_d.d_valid  = 1'b0;
    tl_d.d_error  = 1'b0;
  endtask

  task automatic finish_rsp(input int rsp_stall, input logic [31:0] exp_rdata,
                            input logic exp_err, input logic exp_to);
    for (int i = 0; i <= rsp_stall; i++) begin
      chk("rsp_valid", {31'b0, rsp_valid}, 32'h1);
      chk("rsp_rdata", rsp_rdata, exp_rdata);
      chk("rsp_error", {31'b0, rsp_error}, {31'b0, exp_err});
      chk("rsp_timeout", {31'b0, rsp_timeout}, {31'b0, exp_to});
      chk("cmd_ready_rsp", {31'b0, cmd_ready}, 32'h0);
      rsp_ready = (i == rsp_stall);
      cyc();
    end
    rsp_ready = 1'b0;
    chk("rsp_valid_done", {31'b0, rsp_valid}, 32'h0);
    chk("busy_done", {31'b0, busy}, 32'h0);
    chk("cmd_ready_done", {31'b0, cmd_ready}, 32'h1);
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_cmd_ready"}, {31'b0, cmd_ready}, 32'h1);
    chk({tag, "_a_valid"}, {31'b0, tl_h.a_valid}, 32'h0);
    chk({tag, "_d_ready"}, {31'b0, tl_h.d_ready}, 32'h1);
    chk({tag, "_rsp_valid"}, {31'b0, rsp_valid}, 32'h0);
    chk({tag, "_rsp_rdata"}, rsp_rdata, 32'h0);
    chk({tag, "_rsp_error"}, {31'b0, rsp_error}, 32'h0);
    chk({tag, "_rsp_timeout"}, {31'b0, rsp_timeout}, 32'h0);
    chk({tag, "_busy"}, {31'b0, busy}, 32'h0);
  endtask

  initial begin
    tl_d = '0;
    #1 rst = 1'b1;
    repeat (3) @(negedge clk);
    chk_reset_state("rst_held");
    rst = 1'b0;
    repeat (3) cyc();
    chk_reset_state("rst_rel");

    // Stray response in IDLE is dropped
    tl_d.d_valid  = 1'b1;
    tl_d.d_opcode = AccessAckData;
    tl_d.d_data   = 32'h1111_2222;
    cyc();
    tl_d.d_valid  = 1'b0;
    chk("stray_rsp_valid", {31'b0, rsp_valid}, 32'h0);
    chk("stray_rdata", rsp_rdata, 32'h0);

    // Write CTRL, full mask
    issue(1'b1, 32'h000, 32'h0000_0001, 4'hF, 0, 3'h0, 4'hF);
    respond(1'b1, 32'h000, 32'h0000_0001, 4'hF);
    finish_rsp(0, 32'h0, 1'b0, 1'b0);

    // Partial write of COMPARE_LOWER0_0 then read back
    issue(1'b1, 32'h10C, 32'h0000_0040, 4'h3, 0, 3'h1, 4'h3);
    respond(1'b1, 32'h10C, 32'h0000_0040, 4'h3);
    finish_rsp(0, 32'h0, 1'b0, 1'b0);
    issue(1'b0, 32'h10C, 32'h0, 4'h0, 0, 3'h4, 4'hF);
    respond(1'b0, 32'h10C, 32'h0, 4'h0);
    finish_rsp(0, 32'h0000_0040, 1'b0, 1'b0);

    // Read TIMER_V_LOWER0 under 5 cycles of A back-pressure
    issue(1'b0, 32'h104, 32'h0, 4'h0, 5, 3'h4, 4'hF);
    respond(1'b0, 32'h104, 32'h0, 4'h0);
    finish_rsp(0, 32'h0000_1234, 1'b0, 1'b0);

    // Unaligned read is issued word-aligned (0x003 -> CTRL)
    issue(1'b0, 32'h003, 32'h0, 4'h2, 0, 3'h4, 4'hF);
    respond(1'b0, 32'h003, 32'h0, 4'h2);
    finish_rsp(0, 32'h0000_0001, 1'b0, 1'b0);

    // Unmapped read with response back-pressure
    issue(1'b0, 32'h800, 32'h0, 4'h0, 0, 3'h4, 4'hF);
    respond(1'b0, 32'h800, 32'h0, 4'h0);
    finish_rsp(3, 32'h0, 1'b1, 1'b0);

`ifdef TLUL_CMD_HOST_TIMEOUT_EN
    // Silent device: expiry 16 cycles after entering D_WAIT
    issue(1'b0, 32'h104, 32'h0, 4'h0, 0, 3'h4, 4'hF);
    for (int k = 0; k < 16; k++) begin
      chk("to_wait_rsp_valid", {31'b0, rsp_valid}, 32'h0);
      cyc();
    end
    finish_rsp(0, 32'h0, 1'b1, 1'b1);
    // Late response lands in IDLE and is dropped
    tl_d.d_valid  = 1'b1;
    tl_d.d_opcode = AccessAckData;
    tl_d.d_data   = 32'h0000_1234;
    cyc();
    tl_d.d_valid  = 1'b0;
    chk("late_rsp_valid", {31'b0, rsp_valid}, 32'h0);
    chk("late_rsp_timeout", {31'b0, rsp_timeout}, 32'h1);
`endif

    // Reset while the A request is pending; leaves rsp_error set beforehand
    issue(1'b0, 32'h800, 32'h0, 4'h0, 0, 3'h4, 4'hF);
    respond(1'b0, 32'h800, 32'h0, 4'h0);
    finish_rsp(0, 32'h0, 1'b1, 1'b0);
    cmd_valid = 1'b1;
    cmd_write = 1'b0;
    cmd_addr  = 32'h104;
    cyc();
    cmd_valid = 1'b0;
    chk("pre_rst_a_valid", {31'b0, tl_h.a_valid}, 32'h1);
    rst = 1'b1;
    #1;
    chk("rst_a_valid_now", {31'b0, tl_h.a_valid}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) cyc();
    chk_reset_state("rst_mid");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/tlul_cmd_host.md
# tlul_cmd_host

Single-outstanding TL-UL host that converts a simple valid/ready command stream (read/write, address, data, mask) into TL-UL A-channel requests and returns D-channel responses on a valid/ready response port. It sits directly upstream of the rv_timer register interface in the fuzzing harness: the fuzz-input decoder feeds it commands, and it drives `tl_i` of the timer. It enforces TL-UL handshake rules and holds the A-channel stable under back-pressure. It bounds response latency with an optional timeout.

## Interface
- `TimeoutCycles`, default 1024: D-channel wait limit in cycles (≥2); used only with the timeout feature.
- `SourceId`, default 8'h00: constant `a_source` value.
- `clk_i`  in  1  clock.
- `rst_i`  in  1  asynchronous, active-high reset.
- `cmd_valid_i`  in  1  command valid.
- `cmd_ready_o`  out  1  command accepted when valid&&ready.
- `cmd_write_i`  in  1  1=write, 0=read.
- `cmd_addr_i`  in  32  byte address; bits [1:0] forced to 0 on issue.
- `cmd_wdata_i`  in  32  write data.
- `cmd_mask_i`  in  4  byte-enable for writes; ignored for reads.
- `rsp_valid_o`  out  1  response valid, held until `rsp_ready_i`.
- `rsp_ready_i`  in  1  response consumer ready.
- `rsp_rdata_o`  out  32  read data (0 for writes, errors, and timeouts).
- `rsp_error_o`  out  1  `d_error` seen, or timeout.
- `rsp_timeout_o`  out  1  response produced by timeout.
- `busy_o`  out  1  state ≠ IDLE.
- `tl_o`  out  tlul_pkg::tl_h2d_t  to device.
- `tl_i`  in  tlul_pkg::tl_d2h_t  from device.

## Operation
- FSM states: IDLE, A_REQ, D_WAIT, RSP.
- IDLE: `cmd_ready_o`=1, `d_ready`=1. Any `d_valid` here is discarded as stray. On a cmd handshake, register all command fields and go to A_REQ.
- A_REQ: `a_valid`=1; all A fields come from registers and stay stable until `a_ready`. On `a_ready`, go to D_WAIT. `d_ready`=0.
- A-field encoding:
  - read → Get, mask 4'hF.
  - write with mask 4'hF → PutFullData.
  - write with any other mask → PutPartialData.
  - `a_size`=2, `a_param`=0, `a_source`=SourceId, `a_user`=tlul_pkg::TL_A_USER_DEFAULT.
- D_WAIT: `d_ready`=1. On `d_valid`:
  - capture `rsp_rdata_o` (only for a read with `d_opcode`=AccessAckData and `d_error`=0; otherwise 0).
  - capture `rsp_error_o`=`d_error`, `rsp_timeout_o`=0.
  - go to RSP.
- RSP: `rsp_valid_o`=1. On `rsp_ready_i`, go to IDLE.
- Response fields hold their value until the next capture.
- Strictly one transaction outstanding; commands are never reordered or dropped.

## Timing
- Reset (async assert, sync deassert internally) gives state=IDLE with: `cmd_ready_o`=1, `a_valid`=0, `d_ready`=1, `rsp_valid_o`=0, `rsp_rdata_o`=0, `rsp_error_o`=0, `rsp_timeout_o`=0, `busy_o`=0, and the timeout counter at 0.
- Cycle accounting:
  - The cmd handshake at cycle N gives `a_valid` at N+1.
  - With `a_ready`=1 at N+1 and `d_valid` at N+2, `rsp_valid_o` rises at N+3.
  - Minimum 4 cycles per command.
- `cmd_ready_o` is 0 in every state except IDLE. A new command is therefore accepted, at the earliest, in the cycle after the `rsp` handshake.
- `d_valid` never arrives in the same cycle as the A handshake: the device registers its response, and the host does not look for it then.
- Reset mid-transaction: `a_valid` drops immediately and any pending response is lost. The bench must not expect completion.
- `rsp_valid_o` is never withdrawn before `rsp_ready_i`.

## Configuration
- Macro: `TLUL_CMD_HOST_TIMEOUT_EN`.
- When defined:
  - A counter increments each cycle in D_WAIT and clears on entering D_WAIT.
  - When it reaches TimeoutCycles-1 with no `d_valid`, go to RSP with `rsp_error_o`=1, `rsp_timeout_o`=1, `rsp_rdata_o`=0.
  - If `d_valid` arrives in that same final cycle, the real response wins.
  - A late response arrives in IDLE and is discarded.
- When undefined: no counter exists, D_WAIT waits indefinitely, and `rsp_timeout_o` is tied to 0.

## Structure
- Package `tlul_cmd_host_pkg`: `state_e` enum (IDLE, A_REQ, D_WAIT, RSP) and a `cmd_t` struct {write, addr, wdata, mask}.
- TL opcodes and types come from `tlul_pkg`.
- One sub-module, `tlul_cmd_host_tmr`: the timeout counter, with inputs clear/enable and output expired. It is instantiated only under the macro.

## Test plan
- Write CTRL: addr 0x000, wdata 0x1, mask 0xF → `a_opcode`=PutFullData, `a_address`=0x000; response `rsp_error_o`=0, `rsp_rdata_o`=0.
- Write COMPARE_LOWER0_0 (0x10C) with 0x0000_0040, mask 0x3 → PutPartialData with mask 0x3. A following read of 0x10C returns 0x0000_0040.
- Read TIMER_V_LOWER0 (0x104) with `a_ready` held low 5 cycles → A fields stable across all 6 cycles of `a_valid`; exactly one A handshake.
- Read unmapped 0x800 → `rsp_error_o`=1, `rsp_rdata_o`=0. Also: `rsp_ready_i` low 3 cycles → `rsp_valid_o` held and `cmd_ready_o`=0 throughout.
- With `TLUL_CMD_HOST_TIMEOUT_EN`, TimeoutCycles=16, device D-channel stubbed silent → `rsp_valid_o` rises 16 cycles after entering D_WAIT with error=1 and timeout=1.
- Assert `rst_i` in A_REQ → same cycle `a_valid`=0; after release, IDLE with `cmd_ready_o`=1 and all response outputs 0.
